// File: rtl/otp_pad_engine.sv
// otp_pad_engine: one-time-pad cipher engine with LFSR pads, slot store and valid/ready streaming
module otp_pad_engine #(
    parameter int DATA_W = 8,
    parameter int PAD_DEPTH = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
    parameter logic [DATA_W-1:0] LFSR_SEED = 8'h01,
    localparam int IDX_W = $clog2(PAD_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_err,
    output logic [IDX_W:0]    pad_count,
    output logic              pad_full
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [DATA_W-1:0] lfsr, lfsr_step;
    logic [DATA_W-1:0] pad_mem [PAD_DEPTH];
    logic [PAD_DEPTH-1:0] slot_valid;
    logic [IDX_W-1:0] wr_ptr;
    logic accept, enc_ok, dec_ok;
    assign out_valid = state == FULL;
    assign in_ready = en & (~out_valid | out_ready);
    assign accept = in_valid & in_ready;
    assign enc_ok = accept & ~in_mode & ~slot_valid[wr_ptr];
    assign dec_ok = accept & in_mode & slot_valid[in_idx];
    assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
    assign pad_full = slot_valid[wr_ptr];
    // output register holds a result from accept until it is consumed without a replacement
    always_comb begin
        state_nx = state;
        if (accept) state_nx = FULL;
        else if (out_ready) state_nx = EMPTY;
    end
    // state register; draining via out_ready works even while en is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else state <= state_nx;
    end
    // Galois LFSR advances on every enabled cycle, reseeding if it ever hits zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else if (en) lfsr <= (lfsr_step == '0) ? LFSR_SEED : lfsr_step;
    end
    // pad RAM has no reset; only the valid bits define occupancy
    always_ff @(posedge clk) begin
        if (enc_ok) pad_mem[wr_ptr] <= lfsr;
    end
    // slot occupancy, write pointer and occupied-slot count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid <= '0;
            wr_ptr <= '0;
            pad_count <= '0;
        end else if (enc_ok) begin
            slot_valid[wr_ptr] <= 1'b1;
            wr_ptr <= wr_ptr + IDX_W'(1);
            pad_count <= pad_count + (IDX_W+1)'(1);
        end else if (dec_ok) begin
            slot_valid[in_idx] <= 1'b0;
            pad_count <= pad_count - (IDX_W+1)'(1);
        end
    end
    // result fields load only on accept so they stay stable while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data <= '0;
            out_idx <= '0;
            out_err <= 1'b0;
        end else if (accept) begin
            out_idx <= in_mode ? in_idx : wr_ptr;
            out_err <= in_mode ? ~slot_valid[in_idx] : slot_valid[wr_ptr];
            out_data <= in_mode ? (slot_valid[in_idx] ? in_data ^ pad_mem[in_idx] : '0)
                                : (slot_valid[wr_ptr] ? '0 : in_data ^ lfsr);
        end
    end
endmodule

// File: tb/tb_otp_pad_engine.sv
// tb_otp_pad_engine: directed and random checks of otp_pad_engine against a behavioural model
module tb_otp_pad_engine;
    logic clk = 0, reset = 1, en = 0, in_valid = 0, in_mode = 0, out_ready = 0;
    logic [2:0] in_idx = '0;
    logic [7:0] in_data = '0;
    logic in_ready, out_valid, out_err, pad_full;
    logic [7:0] out_data;
    logic [2:0] out_idx;
    logic [3:0] pad_count;
    int total = 0, bad = 0;
    logic [7:0] m_lfsr, m_data;
    logic [7:0] m_pad [8];
    logic [7:0] m_valid;
    logic [2:0] m_wr, m_idx;
    logic m_ov, m_err;

    always #5 clk = ~clk;

    otp_pad_engine dut (
        .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_idx(in_idx), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_err(out_err),
        .pad_count(pad_count), .pad_full(pad_full)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] next_pad(input logic [7:0] s);
        logic [7:0] n;
        n = (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
        return (n == 8'h00) ? 8'h01 : n;
    endfunction

    task automatic model_reset();
        m_lfsr = 8'h01;
        m_valid = '0;
        m_wr = '0;
        m_ov = 0;
        m_err = 0;
        m_data = '0;
        m_idx = '0;
    endtask

    task automatic do_reset();
        en = 0; in_valid = 0; out_ready = 0;
        reset = 1;
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst out_idx", 32'(out_idx), 0);
        chk("rst out_err", 32'(out_err), 0);
        chk("rst pad_count", 32'(pad_count), 0);
        chk("rst pad_full", 32'(pad_full), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic step(input logic e, input logic v, input logic m, input logic [2:0] i,
                        input logic [7:0] d, input logic r);
        logic acc;
        en = e; in_valid = v; in_mode = m; in_idx = i; in_data = d; out_ready = r;
        #1;
        acc = e & (~m_ov | r);
        chk("in_ready", 32'(in_ready), 32'(acc));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_idx", 32'(out_idx), 32'(m_idx));
            chk("out_err", 32'(out_err), 32'(m_err));
        end
        chk("pad_count", 32'(pad_count), 32'($countones(m_valid)));
        chk("pad_full", 32'(pad_full), 32'(m_valid[m_wr]));
        acc = acc & v;
        if (acc) begin
            m_ov = 1;
            if (!m) begin
                m_idx = m_wr;
                if (m_valid[m_wr]) begin
                    m_err = 1; m_data = '0;
                end else begin
                    m_err = 0; m_data = d ^ m_lfsr;
                    m_pad[m_wr] = m_lfsr; m_valid[m_wr] = 1'b1;
                    m_wr = m_wr + 3'd1;
                end
            end else begin
                m_idx = i;
                if (m_valid[i]) begin
                    m_err = 0; m_data = d ^ m_pad[i]; m_valid[i] = 1'b0;
                end else begin
                    m_err = 1; m_data = '0;
                end
            end
        end else if (r) m_ov = 0;
        if (e) m_lfsr = next_pad(m_lfsr);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("init out_valid", 32'(out_valid), 0);
        chk("init pad_count", 32'(pad_count), 0);
        reset = 0;
        step(1, 1, 0, 3'd0, 8'hA5, 1);
        chk("t1 data", 32'(out_data), 32'h A4);
        chk("t1 idx", 32'(out_idx), 0);
        chk("t1 err", 32'(out_err), 0);
        chk("t1 cnt", 32'(pad_count), 1);
        step(1, 1, 0, 3'd0, 8'h3C, 1);
        chk("t2 enc data", 32'(out_data), 32'h84);
        chk("t2 enc idx", 32'(out_idx), 1);
        step(1, 1, 1, 3'd1, 8'h84, 1);
        chk("t2 dec data", 32'(out_data), 32'h3C);
        chk("t2 dec cnt", 32'(pad_count), 1);
        step(1, 1, 1, 3'd1, 8'h84, 1);
        chk("t2 redec err", 32'(out_err), 1);
        chk("t2 redec data", 32'(out_data), 0);
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1, 1, 0, 3'($urandom), 8'($urandom), 1);
            chk("t3 idx", 32'(out_idx), 32'(k));
        end
        chk("t3 full", 32'(pad_full), 1);
        chk("t3 cnt", 32'(pad_count), 8);
        step(1, 1, 0, 3'd0, 8'($urandom), 1);
        chk("t3 ovf err", 32'(out_err), 1);
        chk("t3 ovf idx", 32'(out_idx), 0);
        step(1, 1, 1, 3'd0, 8'($urandom), 1);
        chk("t3 not full", 32'(pad_full), 0);
        step(1, 1, 0, 3'd5, 8'($urandom), 1);
        chk("t3 wrap idx", 32'(out_idx), 0);
        chk("t3 wrap err", 32'(out_err), 0);
        repeat (5) step(1, 1, 1, 3'($urandom), 8'($urandom), 0);
        for (int k = 0; k < 8; k++) step(1, 1, 1, 3'(k), 8'($urandom), 1);
        repeat (3) step(1, 1, 0, 3'd0, 8'($urandom), 1);
        repeat (4) step(0, 1, 0, 3'd0, 8'($urandom), 1'($urandom));
        repeat (3) step(1, 1, 0, 3'd0, 8'($urandom), 1);
        do_reset();
        repeat (3) step(1, 1, 0, 3'd0, 8'($urandom), 1);
        do_reset();
        step(1, 1, 1, 3'd0, 8'h55, 1);
        chk("t6 dec err", 32'(out_err), 1);
        chk("t6 dec data", 32'(out_data), 0);
        repeat (600) step($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                          3'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
